argon_mem_responder: RTL and testbench



---
 rtl/argon_mem_pkg.sv | 22 ++
 rtl/argon_mem_lane_extract.sv | 43 ++++
 rtl/argon_mem_responder.sv | 148 ++++++++++++++
 tb/tb_argon_mem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/argon_mem_pkg.sv
// Shared bus encodings and responder FSM state type for the Argon memory interface.
// The core imports this package for its read/write mask constants.
package argon_mem_pkg;

    localparam logic [2:0] RDMASK_XX = 3'd0;
    localparam logic [2:0] RDMASK_W  = 3'd1;
    localparam logic [2:0] RDMASK_HE = 3'd2;
    localparam logic [2:0] RDMASK_HZ = 3'd3;
    localparam logic [2:0] RDMASK_BE = 3'd4;
    localparam logic [2:0] RDMASK_BZ = 3'd5;

    localparam logic [1:0] WRMASK_N = 2'd0;
    localparam logic [1:0] WRMASK_W = 2'd1;
    localparam logic [1:0] WRMASK_H = 2'd2;
    localparam logic [1:0] WRMASK_B = 2'd3;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } mem_state_e;

endpackage

// File: rtl/argon_mem_lane_extract.sv
// Combinational load lane select: picks word/halfword/byte from a 32-bit word and extends it.
// Shared with the core's load writeback path.
module argon_mem_lane_extract
    import argon_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_rd_mask,
    output logic [31:0] o_data,
    output logic        o_misalign
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    assign w_byte = i_word[8*i_addr_lo +: 8];

    always_comb begin
        o_data     = '0;
        o_misalign = 1'b0;
        case (i_rd_mask)
            RDMASK_XX: ;
            RDMASK_W: begin
                o_data     = i_word;
                o_misalign = |i_addr_lo;
            end
            RDMASK_HE: begin
                o_data     = {{16{w_half[15]}}, w_half};
                o_misalign = i_addr_lo[0];
            end
            RDMASK_HZ: begin
                o_data     = {16'h0000, w_half};
                o_misalign = i_addr_lo[0];
            end
            RDMASK_BE: o_data = {{24{w_byte[7]}}, w_byte};
            RDMASK_BZ: o_data = {24'h00_0000, w_byte};
            // Unassigned encodings are reported as misaligned with zero data.
            default:   o_misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/argon_mem_responder.sv
// Memory-side responder for the Argon core bus: DEPTH x 32 storage with lane writes,
// registered extended reads, a post-reset clear sweep (o_busy) and fault reporting.
module argon_mem_responder
    import argon_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [31:0] INIT_WORD      = 32'h0000_0000
)
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wr_data,
    input  logic [2:0]  i_mem_rd_mask,
    input  logic [1:0]  i_mem_wr_mask,
    output logic [31:0] o_mem_rd_data,
    output logic        o_busy,
    output logic        o_fault,
    output logic        o_fault_sticky,
    output logic [7:0]  o_fault_count
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam mem_state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic [31:0]       r_mem [DEPTH];
    mem_state_e        r_state;
    mem_state_e        w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [31:0]       r_rd_data;
    logic              r_fault;
    logic              r_fault_sticky;
    logic [7:0]        r_fault_count;

    logic              w_idle;
    logic [ADDR_W-1:0] w_idx;
    logic              w_oor;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_rd_ext;
    logic              w_rd_misalign;
    logic              w_rd_fault;
    logic              w_wr_misalign;
    logic              w_wr_fault;
    logic              w_wr_en;
    logic [31:0]       w_bmask;
    logic [31:0]       w_wdata;
    logic              w_fault;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_idx     = i_mem_addr[ADDR_W+1:2];
    assign w_oor     = |i_mem_addr[31:ADDR_W+2];
    assign w_rd_word = r_mem[w_idx];

    argon_mem_lane_extract u_lane_extract (
        .i_word     (w_rd_word),
        .i_addr_lo  (i_mem_addr[1:0]),
        .i_rd_mask  (i_mem_rd_mask),
        .o_data     (w_rd_ext),
        .o_misalign (w_rd_misalign)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == '1) w_state_next = ST_IDLE;
            ST_IDLE:  w_state_next = ST_IDLE;
            default:  w_state_next = RESET_STATE;
        endcase
    end

    assign o_busy = (r_state == ST_CLEAR);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= RESET_STATE;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    always_comb begin
        w_wr_misalign = 1'b0;
        w_bmask       = '0;
        w_wdata       = i_mem_wr_data;
        case (i_mem_wr_mask)
            WRMASK_W: begin
                w_wr_misalign = |i_mem_addr[1:0];
                w_bmask       = '1;
            end
            WRMASK_H: begin
                w_wr_misalign = i_mem_addr[0];
                w_bmask       = i_mem_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                w_wdata       = {2{i_mem_wr_data[15:0]}};
            end
            WRMASK_B: begin
                w_bmask = 32'h0000_00FF << {i_mem_addr[1:0], 3'b000};
                w_wdata = {4{i_mem_wr_data[7:0]}};
            end
            default: ;
        endcase
    end

    assign w_wr_fault = (i_mem_wr_mask != WRMASK_N) && (w_wr_misalign || w_oor);
    assign w_wr_en    = w_idle && (i_mem_wr_mask != WRMASK_N) && !w_wr_fault;
    assign w_rd_fault = (i_mem_rd_mask != RDMASK_XX) && (w_rd_misalign || w_oor);
    assign w_fault    = w_idle && (w_rd_fault || w_wr_fault);

    // Storage has no reset; the sweep owns the write port while clearing.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_cnt] <= INIT_WORD;
        end else if (w_wr_en) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~w_bmask) | (w_wdata & w_bmask);
        end
    end

    // Read data is taken from the pre-edge array contents, giving read-before-write.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_data      <= '0;
            r_fault        <= 1'b0;
            r_fault_sticky <= 1'b0;
            r_fault_count  <= '0;
        end else begin
            r_fault <= w_fault;
            if (w_idle) begin
                if (w_rd_fault) begin
                    r_rd_data <= '0;
                end else if (i_mem_rd_mask != RDMASK_XX) begin
                    r_rd_data <= w_rd_ext;
                end
            end
            if (w_fault) begin
                r_fault_sticky <= 1'b1;
                if (r_fault_count != 8'hFF) r_fault_count <= r_fault_count + 8'd1;
            end
        end
    end

    assign o_mem_rd_data  = r_rd_data;
    assign o_fault        = r_fault;
    assign o_fault_sticky = r_fault_sticky;
    assign o_fault_count  = r_fault_count;

endmodule

// File: tb/tb_argon_mem_responder.sv
// Directed bench for argon_mem_responder (ADDR_W=4, clear sweep enabled).
module tb_argon_mem_responder;
    import argon_mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  rd_mask;
    logic [1:0]  wr_mask;
    logic [31:0] rd_data;
    logic        busy;
    logic        fault;
    logic        sticky;
    logic [7:0]  fcnt;

    int checks = 0;
    int errors = 0;

    argon_mem_responder #(
        .ADDR_W         (4),
        .CLEAR_ON_RESET (1'b1),
        .INIT_WORD      (32'h0000_0000)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_mem_addr     (addr),
        .i_mem_wr_data  (wdata),
        .i_mem_rd_mask  (rd_mask),
        .i_mem_wr_mask  (wr_mask),
        .o_mem_rd_data  (rd_data),
        .o_busy         (busy),
        .o_fault        (fault),
        .o_fault_sticky (sticky),
        .o_fault_count  (fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  wr;
        logic [2:0]  rd;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_fault;
        logic        exp_sticky;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [1:0] w, input logic [2:0] r, input logic [31:0] a, input logic [31:0] d);
        wr_mask = w;
        rd_mask = r;
        addr    = a;
        wdata   = d;
    endtask

    task automatic add(input string n, input logic [1:0] w, input logic [2:0] r, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] er, input logic ef, input logic es,
                       input logic [7:0] ec);
        vecs.push_back('{n, w, r, a, d, er, ef, es, ec});
    endtask

    // Counts busy cycles after reset release; bounded so a stuck o_busy still terminates.
    task automatic count_busy(output int n, output logic saw_fault);
        n = 0;
        saw_fault = 1'b0;
        while (busy && n < 100) begin
            step();
            n++;
            if (fault) saw_fault = 1'b1;
        end
    endtask

    initial begin
        int   n;
        logic sf;

        add("wr_w_10",     WRMASK_W, RDMASK_XX, 32'h10,   32'h8000_1234, 32'h0000_0000, 0, 0, 0);
        add("rd_w_10",     WRMASK_N, RDMASK_W,  32'h10,   32'h0,         32'h8000_1234, 0, 0, 0);
        add("rd_he_12",    WRMASK_N, RDMASK_HE, 32'h12,   32'h0,         32'hFFFF_8000, 0, 0, 0);
        add("rd_hz_12",    WRMASK_N, RDMASK_HZ, 32'h12,   32'h0,         32'h0000_8000, 0, 0, 0);
        add("wr_w_20",     WRMASK_W, RDMASK_XX, 32'h20,   32'h1122_3344, 32'h0000_8000, 0, 0, 0);
        add("wr_b_21",     WRMASK_B, RDMASK_XX, 32'h21,   32'hFFFF_FFA5, 32'h0000_8000, 0, 0, 0);
        add("rd_w_20",     WRMASK_N, RDMASK_W,  32'h20,   32'h0,         32'h1122_A544, 0, 0, 0);
        add("rd_be_21",    WRMASK_N, RDMASK_BE, 32'h21,   32'h0,         32'hFFFF_FFA5, 0, 0, 0);
        add("rd_bz_21",    WRMASK_N, RDMASK_BZ, 32'h21,   32'h0,         32'h0000_00A5, 0, 0, 0);
        add("rd_be_22",    WRMASK_N, RDMASK_BE, 32'h22,   32'h0,         32'h0000_0022, 0, 0, 0);
        add("wr_h_22",     WRMASK_H, RDMASK_XX, 32'h22,   32'h1234_BEEF, 32'h0000_0022, 0, 0, 0);
        add("rd_w_20b",    WRMASK_N, RDMASK_W,  32'h20,   32'h0,         32'hBEEF_A544, 0, 0, 0);
        add("rd_he_20",    WRMASK_N, RDMASK_HE, 32'h20,   32'h0,         32'hFFFF_A544, 0, 0, 0);
        add("rd_xx_hold",  WRMASK_N, RDMASK_XX, 32'h0,    32'h0,         32'hFFFF_A544, 0, 0, 0);
        add("wr_w_mis06",  WRMASK_W, RDMASK_XX, 32'h06,   32'hCAFE_F00D, 32'hFFFF_A544, 1, 1, 1);
        add("rd_he_mis03", WRMASK_N, RDMASK_HE, 32'h03,   32'h0,         32'h0000_0000, 1, 1, 2);
        add("rd_w_04",     WRMASK_N, RDMASK_W,  32'h04,   32'h0,         32'h0000_0000, 0, 1, 2);
        add("rdwr_same08", WRMASK_W, RDMASK_W,  32'h08,   32'hDEAD_BEEF, 32'h0000_0000, 0, 1, 2);
        add("rd_w_08",     WRMASK_N, RDMASK_W,  32'h08,   32'h0,         32'hDEAD_BEEF, 0, 1, 2);
        add("rd_mask6",    WRMASK_N, 3'd6,      32'h00,   32'h0,         32'h0000_0000, 1, 1, 3);
        add("rd_oor",      WRMASK_N, RDMASK_W,  32'h1000, 32'h0,         32'h0000_0000, 1, 1, 4);
        add("rdwr_oor",    WRMASK_W, RDMASK_W,  32'h1000, 32'h55,        32'h0000_0000, 1, 1, 5);
        add("rd_w_00",     WRMASK_N, RDMASK_W,  32'h00,   32'h0,         32'h0000_0000, 0, 1, 5);

        rst_n = 1'b0;
        bus(WRMASK_N, RDMASK_XX, 32'h0, 32'h0);
        step();
        step();
        check("rst_busy",   {31'b0, busy},   32'd1);
        check("rst_rd",     rd_data,         32'd0);
        check("rst_fault",  {31'b0, fault},  32'd0);
        check("rst_sticky", {31'b0, sticky}, 32'd0);
        check("rst_cnt",    {24'b0, fcnt},   32'd0);

        // Bus activity during the sweep must be ignored entirely.
        bus(WRMASK_W, 3'd6, 32'h0, 32'hFFFF_FFFF);
        rst_n = 1'b1;
        count_busy(n, sf);
        bus(WRMASK_N, RDMASK_XX, 32'h0, 32'h0);
        check("sweep_len",       n,              32'd16);
        check("sweep_no_fault",  {31'b0, sf},    32'd0);
        check("sweep_rd_hold",   rd_data,        32'd0);
        check("sweep_cnt",       {24'b0, fcnt},  32'd0);

        for (int i = 0; i < 16; i++) begin
            bus(WRMASK_N, RDMASK_W, 32'(4 * i), 32'h0);
            step();
            check($sformatf("clear_rd_%0d", i), rd_data, 32'd0);
        end

        foreach (vecs[i]) begin
            bus(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d);
            step();
            check({vecs[i].name, "_rd"},     rd_data,                 vecs[i].exp_rd);
            check({vecs[i].name, "_fault"},  {31'b0, fault},          {31'b0, vecs[i].exp_fault});
            check({vecs[i].name, "_sticky"}, {31'b0, sticky},         {31'b0, vecs[i].exp_sticky});
            check({vecs[i].name, "_cnt"},    {24'b0, fcnt},           {24'b0, vecs[i].exp_cnt});
        end

        bus(WRMASK_N, 3'd7, 32'h0, 32'h0);
        for (int i = 0; i < 300; i++) step();
        check("sat_cnt",   {24'b0, fcnt},  32'd255);
        check("sat_fault", {31'b0, fault}, 32'd1);
        bus(WRMASK_N, RDMASK_XX, 32'h0, 32'h0);
        step();
        check("sat_fault_drop", {31'b0, fault}, 32'd0);
        check("sat_cnt_hold",   {24'b0, fcnt},  32'd255);

        // Reset in the middle of a sweep must restart it from word 0.
        rst_n = 1'b0;
        #1;
        check("rst2_busy",   {31'b0, busy},   32'd1);
        check("rst2_sticky", {31'b0, sticky}, 32'd0);
        check("rst2_cnt",    {24'b0, fcnt},   32'd0);
        check("rst2_rd",     rd_data,         32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("mid_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        count_busy(n, sf);
        check("resweep_len", n, 32'd16);
        bus(WRMASK_N, RDMASK_W, 32'h08, 32'h0);
        step();
        check("resweep_rd_08", rd_data, 32'd0);
        bus(WRMASK_N, RDMASK_W, 32'h20, 32'h0);
        step();
        check("resweep_rd_20", rd_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
